// File: rtl/spc700_addw_seq.sv
// spc700_addw_seq: byte-serial sequencer for the SPC700 16-bit word ops ADDW/SUBW/CMPW.
// The low byte is added in LO, the high byte in HI with the chained carry. Registered
// results, flags and write enables are presented for one CE cycle alongside DONE.
module spc700_addw_seq #(
    parameter bit HOLD_RESULT = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ce_i,
    input  logic        start_i,
    input  logic [1:0]  op_i,
    input  logic [15:0] a16_i,
    input  logic [15:0] b16_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] result_o,
    output logic        res_we_o,
    output logic        n_o,
    output logic        v_o,
    output logic        h_o,
    output logic        z_o,
    output logic        c_o,
    output logic [4:0]  flag_we_o
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    localparam logic [1:0] OP_ADDW = 2'b00;
    localparam logic [1:0] OP_SUBW = 2'b01;
    localparam logic [1:0] OP_CMPW = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_LO   = 2'b01,
        S_HI   = 2'b10,
        S_FIN  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [WORD_W-1:0]   a_q, a_d;
    logic [WORD_W-1:0]   bx_q, bx_d;
    logic [BYTE_W-1:0]   lo_q, lo_d;
    logic [BYTE_W-1:0]   hi_q, hi_d;
    logic                c8_q, c8_d;
    logic                c16_q, c16_d;
    logic                h11_q, h11_d;
    logic                vhi_q, vhi_d;

    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [WORD_W-1:0]   result_q, result_d;
    logic                res_we_q, res_we_d;
    logic                n_q, n_d;
    logic                v_q, v_d;
    logic                h_q, h_d;
    logic                z_q, z_d;
    logic                c_q, c_d;
    logic [4:0]          flag_we_q, flag_we_d;

    logic                sub_in_c;
    logic                sub_q_c;
    logic [BYTE_W:0]     lo_sum_c;
    logic [BYTE_W:0]     hi_sum_c;
    logic [4:0]          nib_sum_c;

    // Subtract-style ops invert B and inject a carry of 1.
    assign sub_in_c  = (op_i == OP_SUBW) || (op_i == OP_CMPW);
    assign sub_q_c   = (op_q == OP_SUBW) || (op_q == OP_CMPW);
    assign lo_sum_c  = {1'b0, a_q[7:0]}  + {1'b0, bx_q[7:0]}  + 9'(sub_q_c);
    assign hi_sum_c  = {1'b0, a_q[15:8]} + {1'b0, bx_q[15:8]} + 9'(c8_q);
    assign nib_sum_c = {1'b0, a_q[11:8]} + {1'b0, bx_q[11:8]} + 5'(c8_q);

    // Next-state, byte passes and output register values.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        bx_d      = bx_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        c8_d      = c8_q;
        c16_d     = c16_q;
        h11_d     = h11_q;
        vhi_d     = vhi_q;
        busy_d    = (state_q != S_IDLE);
        done_d    = 1'b0;
        res_we_d  = 1'b0;
        flag_we_d = 5'b00000;
        result_d  = HOLD_RESULT ? result_q : '0;
        n_d       = HOLD_RESULT ? n_q : 1'b0;
        v_d       = HOLD_RESULT ? v_q : 1'b0;
        h_d       = HOLD_RESULT ? h_q : 1'b0;
        z_d       = HOLD_RESULT ? z_q : 1'b0;
        c_d       = HOLD_RESULT ? c_q : 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    a_d     = a16_i;
                    bx_d    = sub_in_c ? ~b16_i : b16_i;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                lo_d    = lo_sum_c[7:0];
                c8_d    = lo_sum_c[8];
                state_d = S_HI;
            end
            S_HI: begin
                hi_d    = hi_sum_c[7:0];
                c16_d   = hi_sum_c[8];
                h11_d   = nib_sum_c[4];
                vhi_d   = ~(a_q[15] ^ bx_q[15]) & (a_q[15] ^ hi_sum_c[7]);
                state_d = S_FIN;
            end
            S_FIN: begin
                done_d   = 1'b1;
                result_d = {hi_q, lo_q};
                n_d      = hi_q[7];
                z_d      = ({hi_q, lo_q} == '0);
                c_d      = c16_q;
                h_d      = h11_q;
                v_d      = vhi_q;
                res_we_d = (op_q == OP_ADDW) || (op_q == OP_SUBW);
                unique case (op_q)
                    OP_ADDW, OP_SUBW: flag_we_d = 5'b11111;
                    OP_CMPW:          flag_we_d = 5'b10011;
                    default:          flag_we_d = 5'b00000;
                endcase
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset overrides CE, CE=0 holds everything.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= 2'b00;
            a_q       <= '0;
            bx_q      <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            c8_q      <= 1'b0;
            c16_q     <= 1'b0;
            h11_q     <= 1'b0;
            vhi_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
            res_we_q  <= 1'b0;
            n_q       <= 1'b0;
            v_q       <= 1'b0;
            h_q       <= 1'b0;
            z_q       <= 1'b0;
            c_q       <= 1'b0;
            flag_we_q <= 5'b00000;
        end else if (ce_i) begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            bx_q      <= bx_d;
            lo_q      <= lo_d;
            hi_q      <= hi_d;
            c8_q      <= c8_d;
            c16_q     <= c16_d;
            h11_q     <= h11_d;
            vhi_q     <= vhi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            result_q  <= result_d;
            res_we_q  <= res_we_d;
            n_q       <= n_d;
            v_q       <= v_d;
            h_q       <= h_d;
            z_q       <= z_d;
            c_q       <= c_d;
            flag_we_q <= flag_we_d;
        end
    end

    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign result_o  = result_q;
    assign res_we_o  = res_we_q;
    assign n_o       = n_q;
    assign v_o       = v_q;
    assign h_o       = h_q;
    assign z_o       = z_q;
    assign c_o       = c_q;
    assign flag_we_o = flag_we_q;

endmodule

// File: tb/tb_spc700_addw_seq.sv
// Bench for spc700_addw_seq: word-level reference model checked every cycle, plus
// hand-computed expectations for the directed vectors.
module tb_spc700_addw_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        busy_o, done_o, res_we_o, n_o, v_o, h_o, z_o, c_o;
    logic [15:0] result_o;
    logic [4:0]  flag_we_o;
    logic [28:0] bundle;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spc700_addw_seq dut (
        .clk_i(clk), .rst_i(rst), .ce_i(ce), .start_i(start), .op_i(op),
        .a16_i(a), .b16_i(b), .busy_o(busy_o), .done_o(done_o), .result_o(result_o),
        .res_we_o(res_we_o), .n_o(n_o), .v_o(v_o), .h_o(h_o), .z_o(z_o), .c_o(c_o),
        .flag_we_o(flag_we_o)
    );

    // {busy, done, result[15:0], res_we, N, V, H, Z, C, flag_we[4:0]}
    assign bundle = {busy_o, done_o, result_o, res_we_o, n_o, v_o, h_o, z_o, c_o, flag_we_o};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Word-level reference: 16-bit arithmetic on whole integers.
    function automatic logic [26:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        bit          sub;
        int          sx, sy, sr, ux, uy, ur;
        logic [15:0] r;
        logic        fn, fv, fh, fz, fc, we;
        logic [4:0]  fwe;
        sub = (o == 2'b01) || (o == 2'b10);
        sx  = int'($signed(x));
        sy  = int'($signed(y));
        ux  = int'(x);
        uy  = int'(y);
        sr  = sub ? sx - sy : sx + sy;
        ur  = sub ? ux - uy : ux + uy;
        r   = 16'(ur);
        fc  = sub ? (ux >= uy) : (ur > 32'h0000FFFF);
        fh  = sub ? ((ux & 32'hFFF) >= (uy & 32'hFFF)) : (((ux & 32'hFFF) + (uy & 32'hFFF)) > 32'hFFF);
        fv  = (sr > 32767) || (sr < -32768);
        fn  = r[15];
        fz  = (r == 16'h0000);
        we  = (o == 2'b00) || (o == 2'b01);
        fwe = we ? 5'b11111 : ((o == 2'b10) ? 5'b10011 : 5'b00000);
        return {r, we, fn, fv, fh, fz, fc, fwe};
    endfunction

    // Model timing: count CE edges from acceptance; completion is visible after the 4th.
    int          m_cnt = 0;
    logic [1:0]  m_op;
    logic [15:0] m_a, m_b;
    logic [28:0] e_out = '0;
    bit          e_full = 1'b1;
    bit          chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  = 0;
            e_out  = '0;
            e_full = 1'b1;
        end else if (ce) begin
            e_out  = '0;
            e_full = 1'b1;
            if (m_cnt == 0) begin
                if (start) begin
                    m_cnt = 1;
                    m_op  = op;
                    m_a   = a;
                    m_b   = b;
                end
            end else begin
                m_cnt++;
            end
            if (m_cnt >= 2) e_out[28] = 1'b1;
            if (m_cnt == 4) begin
                e_out  = {2'b11, model(m_op, m_a, m_b)};
                e_full = (m_op != 2'b11);
                m_cnt  = 0;
            end
        end
    end

    // Per-cycle comparison against the model; reserved op leaves result/flag values unchecked.
    logic [28:0] mask_v;
    always @(negedge clk) begin
        if (chk_en) begin
            mask_v = e_full ? '1 : {2'b11, 16'h0000, 1'b1, 5'b00000, 5'b11111};
            chk("cycle_model", 32'(bundle & mask_v), 32'(e_out & mask_v));
        end
    end

    function automatic logic [28:0] lit(input logic [15:0] r, input logic we,
                                        input logic [4:0] nvhzc, input logic [4:0] fwe);
        return {2'b11, r, we, nvhzc, fwe};
    endfunction

    // Launch one op and wait (bounded) for DONE; poke re-asserts START while busy.
    task automatic run_op(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                          input bit ce_rand, input bit poke,
                          output logic [28:0] got, output int lat);
        bit found;
        found = 1'b0;
        got   = '0;
        lat   = -1;
        @(negedge clk);
        ce = 1'b1; start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = poke; op = ~o; a = ~x; b = ~y;
        for (int k = 0; k < 64 && !found; k++) begin
            if (done_o) begin
                found = 1'b1;
                got   = bundle;
                lat   = k;
            end else begin
                ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                if (k >= 1) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("done_seen", 32'(found), 32'd1);
    endtask

    logic [28:0] got;
    int          lat;
    int          dones;

    initial begin
        rst = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        chk("reset_state", 32'(bundle), 32'd0);
        rst = 1'b0;

        run_op(2'b00, 16'h1234, 16'h0FCD, 1'b0, 1'b0, got, lat);
        chk("addw_1234_0fcd", 32'(got), 32'(lit(16'h2201, 1'b1, 5'b00100, 5'b11111)));
        chk("latency", 32'(lat), 32'd3);

        run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b0, got, lat);
        chk("addw_7fff_0001", 32'(got), 32'(lit(16'h8000, 1'b1, 5'b11100, 5'b11111)));

        run_op(2'b00, 16'hFFFF, 16'h0001, 1'b0, 1'b0, got, lat);
        chk("addw_ffff_0001", 32'(got), 32'(lit(16'h0000, 1'b1, 5'b00111, 5'b11111)));

        run_op(2'b01, 16'h0000, 16'h0001, 1'b0, 1'b0, got, lat);
        chk("subw_0000_0001", 32'(got), 32'(lit(16'hFFFF, 1'b1, 5'b10000, 5'b11111)));

        run_op(2'b10, 16'h8000, 16'h8000, 1'b0, 1'b0, got, lat);
        chk("cmpw_8000_8000", 32'(got), 32'(lit(16'h0000, 1'b0, 5'b00111, 5'b10011)));

        run_op(2'b00, 16'h1234, 16'h0FCD, 1'b1, 1'b0, got, lat);
        chk("addw_ce_toggle", 32'(got), 32'(lit(16'h2201, 1'b1, 5'b00100, 5'b11111)));

        run_op(2'b01, 16'h1000, 16'h0001, 1'b1, 1'b0, got, lat);
        chk("subw_ce_toggle", 32'(got), 32'(lit(16'h0FFF, 1'b1, 5'b00001, 5'b11111)));

        run_op(2'b00, 16'h7FFF, 16'h0001, 1'b0, 1'b1, got, lat);
        chk("start_while_busy", 32'(got), 32'(lit(16'h8000, 1'b1, 5'b11100, 5'b11111)));

        run_op(2'b11, 16'h1111, 16'h2222, 1'b0, 1'b0, got, lat);
        chk("reserved_done", 32'(got[27]), 32'd1);
        chk("reserved_we", 32'({got[10], got[4:0]}), 32'd0);

        // Reset while in HI: no DONE afterwards, outputs cleared.
        @(negedge clk);
        ce = 1'b1; start = 1'b1; op = 2'b00; a = 16'h1234; b = 16'h0FCD;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_in_hi", 32'(bundle), 32'd0);
        rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        chk("no_done_after_reset", 32'(dones), 32'd0);

        // Back-to-back: START held high gives one op per 4 cycles.
        @(negedge clk);
        ce = 1'b1; start = 1'b1; op = 2'b00; a = 16'h0001; b = 16'h0002;
        dones = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        chk("b2b_result", 32'(result_o), 32'h0003);
        start = 1'b0;
        chk("b2b_done_count", 32'(dones), 32'd3);
        for (int k = 0; k < 8; k++) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
